popcount_pipe: RTL

POPCOUNT_PIPE -- requirements
Module: popcount_pipe

---
 rtl/popcount_pipe.sv | 80 ++++++++
 1 files changed

// File: rtl/popcount_pipe.sv
// popcount_pipe: pipelined adder-tree bit counter (N-bit i -> OW-bit o, valid/ready in and out, sync rst); POPCOUNT_ACC_EN adds acc_clr and a saturating AW-bit acc_sum
module popcount_pipe #(
  parameter int N = 7,
  parameter int OW = $clog2(N + 1),
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [OW-1:0] o,
  output logic          out_valid,
  input  logic          out_ready
`ifdef POPCOUNT_ACC_EN
  ,
  input  logic          acc_clr,
  output logic [AW-1:0] acc_sum
`endif
);
  localparam int L = (N > 1) ? $clog2(N) : 1;
  function automatic int cnt(input int k);
    return (N + (1 << (k + 1)) - 1) >> (k + 1);
  endfunction
  function automatic int lw(input int k);
    int m;
    m = ((1 << (k + 1)) < N) ? (1 << (k + 1)) : N;
    return $clog2(m + 1);
  endfunction
  logic stall;
  assign stall = out_valid & ~out_ready;
  assign in_ready = rst | ~stall;
  for (genvar l = 0; l < L; l++) begin : lvl
    localparam int C = cnt(l);
    localparam int W = lw(l);
    localparam int PC = cnt(l - 1);
    localparam int PW = lw(l - 1);
    logic [PW-1:0] src [PC];
    logic [W-1:0] sum [C];
    logic [W-1:0] s [C];
    logic pv;
    logic v;
    if (l == 0) begin : g_in
      for (genvar b = 0; b < N; b++) begin : g_b
        assign src[b] = i[b];
      end
      assign pv = in_valid;
    end else begin : g_up
      assign src = lvl[l-1].s;
      assign pv = lvl[l-1].v;
    end
    for (genvar j = 0; j < C; j++) begin : g_node
      if (2 * j + 1 < PC) begin : g_add
        assign sum[j] = W'(src[2*j]) + W'(src[2*j+1]);
      end else begin : g_pass
        assign sum[j] = W'(src[2*j]);
      end
    end
    always_ff @(posedge clk)
      if (rst) begin
        v <= 1'b0;
        s <= '{default: '0};
      end else if (!stall) begin
        v <= pv;
        s <= sum;
      end
  end
  assign o = OW'(lvl[L-1].s[0]);
  assign out_valid = lvl[L-1].v;
`ifdef POPCOUNT_ACC_EN
  logic out_hs;
  logic [AW:0] acc_add;
  assign out_hs = out_valid & out_ready;
  assign acc_add = {1'b0, acc_sum} + (AW + 1)'(o);
  always_ff @(posedge clk)
    if (rst) acc_sum <= '0;
    else if (acc_clr) acc_sum <= out_hs ? AW'(o) : '0;
    else if (out_hs) acc_sum <= acc_add[AW] ? '1 : acc_add[AW-1:0];
`endif
endmodule
